// File: rtl/coin_credit_fsm.sv
// coin_credit_fsm: accumulates coin credit, dispenses at PRICE,
// returns change / refunds greedily (10/5/2/1), one coin per cycle.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        synchronous active-low reset
//   coin_val     coin value from the priority encoder, 0 = none
//   cancel       level request to abort and refund the credit
//   credit       current credit register
//   dispense     one-cycle pulse, release one drink
//   change_valid one-cycle pulse per returned coin
//   change_coin  value of the returned coin while change_valid, else 0
//   coin_reject  one-cycle pulse, inserted coin goes to the return chute
//   busy         high while dispensing or paying change
module coin_credit_fsm #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          coin_val,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_valid,
    output logic [3:0]          change_coin,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t            state;
    logic [3:0]        prev_coin;
    logic              coin_armed;
    logic              coin_evt;
    logic              coin_legal;
    logic [CREDIT_W:0] sum;
    logic [3:0]        greedy;

    // An event is a 0 -> nonzero transition, only once a 0 has been
    // seen after reset so a coin held through reset is never counted.
    always_comb begin
        coin_evt   = (coin_val != 4'd0) && (prev_coin == 4'd0)
                     && coin_armed;
        coin_legal = (coin_val == 4'd1) || (coin_val == 4'd2)
                     || (coin_val == 4'd5) || (coin_val == 4'd10);
        sum        = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
    end

    // Largest coin not exceeding the remaining credit.
    always_comb begin
        greedy = 4'd0;
        priority case (1'b1)
            credit >= CREDIT_W'(10): greedy = 4'd10;
            credit >= CREDIT_W'(5):  greedy = 4'd5;
            credit >= CREDIT_W'(2):  greedy = 4'd2;
            credit >= CREDIT_W'(1):  greedy = 4'd1;
            default:                 greedy = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 4'd0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
            prev_coin    <= 4'd0;
            coin_armed   <= 1'b0;
        end else begin
            prev_coin <= coin_val;
            if (coin_val == 4'd0) begin
                coin_armed <= 1'b1;
            end
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 4'd0;
            coin_reject  <= 1'b0;

            unique case (state)
                IDLE, COLLECT: begin
                    if (cancel && credit != '0) begin
                        // Cancel beats a same-edge coin; refund the
                        // pre-coin credit.
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= coin_evt;
                    end else if (coin_evt) begin
                        if (!coin_legal) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= sum[CREDIT_W-1:0];
                            if (sum >= PRICE_X) begin
                                state    <= DISPENSE;
                                dispense <= 1'b1;
                                busy     <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_evt;
                    credit      <= credit - PRICE_C;
                    if (credit == PRICE_C) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end
                end
                CHANGE: begin
                    coin_reject  <= coin_evt;
                    change_valid <= 1'b1;
                    change_coin  <= greedy;
                    credit       <= credit - CREDIT_W'(greedy);
                    if (credit == CREDIT_W'(greedy)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_credit_fsm.sv
// tb_coin_credit_fsm: directed vectors for coin_credit_fsm, PRICE=15.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_coin_credit_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] coin_val;
    logic       cancel;
    logic [4:0] credit;
    logic       dispense;
    logic       change_valid;
    logic [3:0] change_coin;
    logic       coin_reject;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    coin_credit_fsm #(.PRICE(15), .CREDIT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_val     (coin_val),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin_on(input logic [3:0] v);
        coin_val = v;
        tick();
    endtask

    task automatic coin_off();
        coin_val = 4'd0;
        tick();
    endtask

    // Quick insert: one edge with the coin, then release.
    task automatic ins(input logic [3:0] v);
        coin_on(v);
        coin_off();
    endtask

    initial begin
        rst_n    = 1'b0;
        coin_val = 4'd10;
        cancel   = 1'b0;

        // 1: reset with a coin held through it
        tick();
        tick();
        chk("rst_credit", credit, 0);
        chk("rst_disp", dispense, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_cc", change_coin, 0);
        chk("rst_rej", coin_reject, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("held_coin_credit", credit, 0);
        coin_off();
        tick();

        // 2: 10 then 5 -> exact price, no change
        coin_on(4'd10);
        chk("t2_c10", credit, 10);
        chk("t2_nodisp", dispense, 0);
        tick();
        tick();
        chk("t2_hold", credit, 10);
        coin_off();
        coin_on(4'd5);
        chk("t2_c15", credit, 15);
        chk("t2_disp", dispense, 1);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_disp_end", dispense, 0);
        chk("t2_c0", credit, 0);
        chk("t2_nocv", change_valid, 0);
        chk("t2_idle", busy, 0);
        tick();
        chk("t2_disp_once", dispense, 0);
        coin_off();

        // 3: 10 + 10 -> dispense, change 5
        coin_on(4'd10);
        tick();
        tick();
        coin_off();
        coin_on(4'd10);
        chk("t3_c20", credit, 20);
        chk("t3_disp", dispense, 1);
        tick();
        chk("t3_c5", credit, 5);
        chk("t3_busy", busy, 1);
        chk("t3_nocv", change_valid, 0);
        tick();
        chk("t3_cv", change_valid, 1);
        chk("t3_cc5", change_coin, 5);
        chk("t3_c0", credit, 0);
        chk("t3_idle", busy, 0);
        coin_off();
        chk("t3_cv_clr", change_valid, 0);
        chk("t3_cc_clr", change_coin, 0);

        // 4: credit 8, cancel -> 5, 2, 1
        ins(4'd5);
        ins(4'd2);
        ins(4'd1);
        chk("t4_c8", credit, 8);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_c8b", credit, 8);
        chk("t4_nocv", change_valid, 0);
        tick();
        chk("t4_cc5", change_coin, 5);
        chk("t4_c3", credit, 3);
        chk("t4_nodisp1", dispense, 0);
        tick();
        chk("t4_cc2", change_coin, 2);
        chk("t4_cv2", change_valid, 1);
        chk("t4_c1", credit, 1);
        tick();
        chk("t4_cc1", change_coin, 1);
        chk("t4_c0", credit, 0);
        chk("t4_idle", busy, 0);
        chk("t4_nodisp2", dispense, 0);
        tick();
        chk("t4_cv_clr", change_valid, 0);

        // 5a: coin during CHANGE is rejected
        ins(4'd10);
        ins(4'd2);
        chk("t5_c12", credit, 12);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        coin_on(4'd2);
        chk("t5_rej", coin_reject, 1);
        chk("t5_cc10", change_coin, 10);
        chk("t5_c2", credit, 2);
        tick();
        chk("t5_rej_once", coin_reject, 0);
        chk("t5_cc2", change_coin, 2);
        chk("t5_c0", credit, 0);
        coin_off();
        chk("t5_c0b", credit, 0);

        // 5b: illegal value 3 in COLLECT
        ins(4'd1);
        chk("t5_c1", credit, 1);
        coin_on(4'd3);
        chk("t5_rej3", coin_reject, 1);
        chk("t5_c1b", credit, 1);
        tick();
        chk("t5_rej3_once", coin_reject, 0);
        coin_off();

        // 6: credit 7, coin 10 + cancel on the same edge
        ins(4'd5);
        ins(4'd1);
        chk("t6_c7", credit, 7);
        coin_val = 4'd10;
        cancel   = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t6_rej", coin_reject, 1);
        chk("t6_c7b", credit, 7);
        chk("t6_busy", busy, 1);
        tick();
        chk("t6_cc5", change_coin, 5);
        chk("t6_c2", credit, 2);
        chk("t6_nodisp", dispense, 0);
        tick();
        chk("t6_cc2", change_coin, 2);
        chk("t6_c0", credit, 0);
        chk("t6_nodisp2", dispense, 0);
        coin_off();

        // 7: reset while dispensing abandons the change
        ins(4'd10);
        coin_on(4'd10);
        chk("t7_disp", dispense, 1);
        rst_n = 1'b0;
        tick();
        chk("t7_disp0", dispense, 0);
        chk("t7_c0", credit, 0);
        chk("t7_busy0", busy, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("t7_nocv", change_valid, 0);
        chk("t7_c0b", credit, 0);
        coin_off();
        coin_on(4'd2);
        chk("t7_rearm", credit, 2);
        coin_off();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
